// File: rtl/mem_seq.sv
// mem_seq - single-byte memory access sequencer.
//
// Holds a 16-bit address pointer loaded from the address unit and runs one
// read or write cycle on the external memory bus per request. It waits for
// mem_rdy, optionally post-increments the pointer on success, and aborts
// with an error after TIMEOUT ACCESS cycles without ready.
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   a, ld             pointer load value and load strobe (IDLE only)
//   rd_req, wr_req    start a read / write (read wins if both are high)
//   inc, wdata        post-increment flag and write byte, sampled with request
//   busy, done, err   status: not idle, one-cycle completion, timeout flag
//   rdata, ptr        last successfully read byte, current pointer
//   mem_*             external memory bus (address, strobes, data, ready)

module mem_seq #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        ld,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        inc,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] ptr,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_rdy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        op_rd;
  logic        op_inc;
  logic [7:0]  wdata_q;
  logic [7:0]  wait_cnt;
  logic        err_q;

  logic        start;
  logic        access_ok;
  logic        access_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. The ready check comes before the timeout check, so a
  // ready in the final permitted cycle still counts as success.
  always_comb begin
    next_state     = state;
    start          = 1'b0;
    access_ok      = 1'b0;
    access_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req || wr_req) begin
          start      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_rdy) begin
          access_ok  = 1'b1;
          next_state = DONE;
        end else if (wait_cnt == LAST_WAIT) begin
          access_timeout = 1'b1;
          next_state     = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath registers. A load in the same cycle as a request lands in ptr
  // on the same edge the FSM enters ACCESS, so the access uses the new address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= 16'h0000;
      rdata    <= 8'h00;
      op_rd    <= 1'b0;
      op_inc   <= 1'b0;
      wdata_q  <= 8'h00;
      wait_cnt <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      if (state == IDLE && ld) begin
        ptr <= a;
      end
      if (start) begin
        op_rd    <= rd_req;
        op_inc   <= inc;
        wdata_q  <= wdata;
        wait_cnt <= 8'h00;
        err_q    <= 1'b0;
      end
      if (state == ACCESS) begin
        if (access_ok) begin
          err_q <= 1'b0;
          if (op_rd) begin
            rdata <= mem_rdata;
          end
          if (op_inc) begin
            ptr <= ptr + 16'h0001;
          end
        end else if (access_timeout) begin
          err_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'h01;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_q;
  assign mem_addr  = ptr;
  assign mem_rd    = (state == ACCESS) && op_rd;
  assign mem_wr    = (state == ACCESS) && !op_rd;
  assign mem_wdata = ((state == ACCESS) && !op_rd) ? wdata_q : 8'h00;

endmodule

// File: tb/tb_mem_seq.sv
// tb_mem_seq - directed self-checking bench for mem_seq (TIMEOUT = 8).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_mem_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        ld;
  logic        rd_req;
  logic        wr_req;
  logic        inc;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic [15:0] ptr;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_rdy;

  int passCount;
  int totalCount;

  mem_seq #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .ld        (ld),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .inc       (inc),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .ptr       (ptr),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full clock: rising edge, then settle to the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive every request-side input at once.
  task automatic applyStimulus(input logic ld_v, input logic [15:0] a_v,
                               input logic rd_v, input logic wr_v,
                               input logic inc_v, input logic [7:0] wd_v);
    ld     = ld_v;
    a      = a_v;
    rd_req = rd_v;
    wr_req = wr_v;
    inc    = inc_v;
    wdata  = wd_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic releaseRequest();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    rst_n      = 1'b0;
    mem_rdy    = 1'b0;
    mem_rdata  = 8'h00;
    releaseRequest();
    @(negedge clk);
    tick();
    tick();

    // Reset state
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_ptr", 32'(ptr), 32'h0);
    checkOutput("rst_rdata", 32'(rdata), 32'h0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'h0);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Pointer load in IDLE
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    releaseRequest();
    checkOutput("ld_ptr", 32'(ptr), 32'h1234);
    checkOutput("ld_busy", 32'(busy), 32'h0);

    // Zero-wait read with post-increment
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00);
    mem_rdy   = 1'b1;
    mem_rdata = 8'hA5;
    tick();
    releaseRequest();
    checkOutput("rd0_mem_rd", 32'(mem_rd), 32'h1);
    checkOutput("rd0_mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("rd0_addr", 32'(mem_addr), 32'h1234);
    checkOutput("rd0_busy", 32'(busy), 32'h1);
    checkOutput("rd0_done_early", 32'(done), 32'h0);
    checkOutput("rd0_wdata_zero", 32'(mem_wdata), 32'h0);
    tick();
    checkOutput("rd0_done", 32'(done), 32'h1);
    checkOutput("rd0_err", 32'(err), 32'h0);
    checkOutput("rd0_rdata", 32'(rdata), 32'hA5);
    checkOutput("rd0_ptr", 32'(ptr), 32'h1235);
    checkOutput("rd0_strobe_off", 32'(mem_rd), 32'h0);
    checkOutput("rd0_addr_done", 32'(mem_addr), 32'h1235);
    mem_rdy = 1'b0;
    tick();
    checkOutput("rd0_idle_done", 32'(done), 32'h0);
    checkOutput("rd0_idle_busy", 32'(busy), 32'h0);

    // Write with two wait cycles, no increment
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h3C);
    tick();
    releaseRequest();
    checkOutput("wr_c1_mem_wr", 32'(mem_wr), 32'h1);
    checkOutput("wr_c1_wdata", 32'(mem_wdata), 32'h3C);
    checkOutput("wr_c1_addr", 32'(mem_addr), 32'h1235);
    checkOutput("wr_c1_mem_rd", 32'(mem_rd), 32'h0);
    tick();
    checkOutput("wr_c2_mem_wr", 32'(mem_wr), 32'h1);
    checkOutput("wr_c2_done", 32'(done), 32'h0);
    tick();
    checkOutput("wr_c3_mem_wr", 32'(mem_wr), 32'h1);
    checkOutput("wr_c3_wdata", 32'(mem_wdata), 32'h3C);
    mem_rdy = 1'b1;
    tick();
    checkOutput("wr_done", 32'(done), 32'h1);
    checkOutput("wr_err", 32'(err), 32'h0);
    checkOutput("wr_ptr", 32'(ptr), 32'h1235);
    checkOutput("wr_strobe_off", 32'(mem_wr), 32'h0);
    checkOutput("wr_rdata_kept", 32'(rdata), 32'hA5);
    mem_rdy = 1'b0;
    tick();

    // Load together with a read: access at the new address, then wrap
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 8'h00);
    mem_rdy   = 1'b1;
    mem_rdata = 8'h5A;
    tick();
    releaseRequest();
    checkOutput("wrap_addr", 32'(mem_addr), 32'hFFFF);
    checkOutput("wrap_mem_rd", 32'(mem_rd), 32'h1);
    tick();
    checkOutput("wrap_ptr", 32'(ptr), 32'h0000);
    checkOutput("wrap_rdata", 32'(rdata), 32'h5A);
    checkOutput("wrap_done", 32'(done), 32'h1);
    mem_rdy = 1'b0;
    tick();

    // Timeout: strobe held exactly 8 cycles; ld/wr_req while busy are ignored
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h00);
    mem_rdata = 8'h77;
    tick();
    releaseRequest();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("to_strobe_%0d", i), 32'(mem_rd), 32'h1);
      checkOutput($sformatf("to_nodone_%0d", i), 32'(done), 32'h0);
      if (i == 2) begin
        applyStimulus(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, 8'h55);
      end else begin
        releaseRequest();
      end
      tick();
    end
    releaseRequest();
    checkOutput("to_done", 32'(done), 32'h1);
    checkOutput("to_err", 32'(err), 32'h1);
    checkOutput("to_ptr", 32'(ptr), 32'h0000);
    checkOutput("to_rdata", 32'(rdata), 32'h5A);
    checkOutput("to_strobe_off", 32'(mem_rd), 32'h0);
    tick();
    checkOutput("to_idle_err", 32'(err), 32'h0);
    checkOutput("to_idle_busy", 32'(busy), 32'h0);
    checkOutput("to_no_queue_wr", 32'(mem_wr), 32'h0);

    // Ready in the eighth (last) ACCESS cycle counts as success
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00);
    mem_rdata = 8'hC3;
    tick();
    releaseRequest();
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    checkOutput("late_strobe_c8", 32'(mem_rd), 32'h1);
    mem_rdy = 1'b1;
    tick();
    checkOutput("late_done", 32'(done), 32'h1);
    checkOutput("late_err", 32'(err), 32'h0);
    checkOutput("late_rdata", 32'(rdata), 32'hC3);
    checkOutput("late_ptr", 32'(ptr), 32'h0000);
    mem_rdy = 1'b0;
    tick();

    // Read and write requested together: read only
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hEE);
    mem_rdy   = 1'b1;
    mem_rdata = 8'h11;
    tick();
    releaseRequest();
    checkOutput("both_mem_rd", 32'(mem_rd), 32'h1);
    checkOutput("both_mem_wr", 32'(mem_wr), 32'h0);
    checkOutput("both_wdata", 32'(mem_wdata), 32'h0);
    tick();
    checkOutput("both_rdata", 32'(rdata), 32'h11);
    checkOutput("both_ptr", 32'(ptr), 32'h0001);
    mem_rdy = 1'b0;
    tick();

    // Reset in the middle of a write access
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h99);
    tick();
    releaseRequest();
    checkOutput("rstmid_mem_wr", 32'(mem_wr), 32'h1);
    rst_n = 1'b0;
    tick();
    checkOutput("rstmid_strobe_off", 32'(mem_wr), 32'h0);
    checkOutput("rstmid_busy", 32'(busy), 32'h0);
    checkOutput("rstmid_done", 32'(done), 32'h0);
    checkOutput("rstmid_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("rstmid_ptr", 32'(ptr), 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("rstmid_no_done", 32'(done), 32'h0);
    checkOutput("rstmid_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
